// File: rtl/mux4_arb_if.sv
// Handshake/data bundle between four requesters, the round-robin arbiter and
// one downstream consumer. master = requester/consumer side, slave = arbiter.
interface mux4_arb_if #(
  parameter int W = 8
);
  logic [3:0]   req;
  logic [W-1:0] i0;
  logic [W-1:0] i1;
  logic [W-1:0] i2;
  logic [W-1:0] i3;
  logic         y_ready;
  logic [W-1:0] y;
  logic         y_valid;
  logic [3:0]   grant;
  logic [1:0]   sel;
  logic         busy;

  modport master (
    output req, i0, i1, i2, i3, y_ready,
    input  y, y_valid, grant, sel, busy
  );

  modport slave (
    input  req, i0, i1, i2, i3, y_ready,
    output y, y_valid, grant, sel, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sequencing a shared 4:1 mux onto one valid/ready output.
// Optional macro MUX4_ARB_HOLD_LIMIT_EN: forces rotation after HOLD_MAX
// accepted beats when another port is waiting; without it a grant lasts until
// its request drops and no beat counter exists.
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests starting after sel
// GRANT | one port owns the mux; its data is presented downstream
module mux4_rr_arbiter #(
  parameter int W        = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  mux4_arb_if.slave  bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must be within 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] win;
  logic [W-1:0] mux_y;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_MAX - 1);
  logic [CW-1:0] beat_cnt, beat_cnt_d;
  logic          accept;
  assign accept = bus.y_valid && bus.y_ready;
`endif

  // Search order sel+1, sel+2, sel+3, sel; the first pending request wins.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    win   = sel_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = sel_q + 2'(k);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state logic: grant from IDLE, release on req drop or hold limit.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    beat_cnt_d = beat_cnt;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          grant_d = 4'b0001 << win;
          sel_d   = win;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
          beat_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
`ifdef MUX4_ARB_HOLD_LIMIT_EN
        else if (accept) begin
          if (beat_cnt == LAST) begin
            beat_cnt_d = '0;
            // Only rotate if someone else is actually waiting.
            if (|(bus.req & ~grant_q)) begin
              state_d = IDLE;
              grant_d = '0;
            end
          end else begin
            beat_cnt_d = beat_cnt + 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant and select registers; sel resets to 3 so port 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= 2'b11;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      beat_cnt <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      beat_cnt <= beat_cnt_d;
`endif
    end
  end

  // Embedded 4:1 datapath mux driven by the registered select.
  always_comb begin
    case (sel_q)
      2'd0:    mux_y = bus.i0;
      2'd1:    mux_y = bus.i1;
      2'd2:    mux_y = bus.i2;
      default: mux_y = bus.i3;
    endcase
  end

  assign bus.busy    = (state_q == GRANT);
  assign bus.y       = bus.busy ? mux_y : '0;
  assign bus.y_valid = bus.busy && bus.req[sel_q];
  assign bus.grant   = grant_q;
  assign bus.sel     = sel_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed-vector bench for mux4_rr_arbiter; hold-limit expectations follow
// MUX4_ARB_HOLD_LIMIT_EN when it is defined for the build.
module tb_mux4_rr_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [W-1:0] dat [4];

  mux4_arb_if #(.W(W)) arb_if ();

  mux4_rr_arbiter #(.W(W), .HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arb_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arb_if.req = 4'b0000;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    arb_if.req     = 4'b0000;
    arb_if.y_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    n_cmp++; if (arb_if.grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got=%b want=0000", arb_if.grant); end
    n_cmp++; if (arb_if.sel !== 2'b11) begin n_err++; $display("FAIL reset_sel got=%b want=11", arb_if.sel); end
    n_cmp++; if (arb_if.y_valid !== 1'b0) begin n_err++; $display("FAIL reset_y_valid got=%b want=0", arb_if.y_valid); end
    n_cmp++; if (arb_if.y !== 8'h00) begin n_err++; $display("FAIL reset_y got=%h want=00", arb_if.y); end
    n_cmp++; if (arb_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", arb_if.busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    arb_if.y_ready = 1'b1;
    arb_if.req     = 4'b0100;
    n_cmp++; if (arb_if.grant !== 4'b0000) begin n_err++; $display("FAIL single_latency got=%b want=0000", arb_if.grant); end
    tick();
    n_cmp++; if (arb_if.grant !== 4'b0100) begin n_err++; $display("FAIL single_grant got=%b want=0100", arb_if.grant); end
    n_cmp++; if (arb_if.sel !== 2'b10) begin n_err++; $display("FAIL single_sel got=%b want=10", arb_if.sel); end
    n_cmp++; if (arb_if.y !== 8'hA5) begin n_err++; $display("FAIL single_y got=%h want=a5", arb_if.y); end
    n_cmp++; if (arb_if.y_valid !== 1'b1) begin n_err++; $display("FAIL single_y_valid got=%b want=1", arb_if.y_valid); end
    n_cmp++; if (arb_if.busy !== 1'b1) begin n_err++; $display("FAIL single_busy got=%b want=1", arb_if.busy); end
    arb_if.req = 4'b0000;
    #1;
    n_cmp++; if (arb_if.y_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drop got=%b want=0", arb_if.y_valid); end
    tick();
    n_cmp++; if (arb_if.grant !== 4'b0000) begin n_err++; $display("FAIL single_release_grant got=%b want=0000", arb_if.grant); end
    n_cmp++; if (arb_if.busy !== 1'b0) begin n_err++; $display("FAIL single_release_busy got=%b want=0", arb_if.busy); end
    n_cmp++; if (arb_if.sel !== 2'b10) begin n_err++; $display("FAIL single_sel_kept got=%b want=10", arb_if.sel); end
    n_cmp++; if (arb_if.y !== 8'h00) begin n_err++; $display("FAIL single_idle_y got=%h want=00", arb_if.y); end
  endtask

  task automatic test_round_robin();
    logic [3:0] oh;
    do_reset();
    arb_if.y_ready = 1'b1;
    arb_if.req     = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      int p;
      p  = k % 4;
      oh = 4'b0001 << p;
      n_cmp++; if (arb_if.grant !== oh) begin n_err++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, arb_if.grant, oh); end
      n_cmp++; if (arb_if.sel !== 2'(p)) begin n_err++; $display("FAIL rr_sel[%0d] got=%0d want=%0d", k, arb_if.sel, p); end
      n_cmp++; if (arb_if.y !== dat[p]) begin n_err++; $display("FAIL rr_y[%0d] got=%h want=%h", k, arb_if.y, dat[p]); end
      tick();
      arb_if.req[p] = 1'b0;
      tick();
      n_cmp++; if (arb_if.grant !== 4'b0000 || arb_if.busy !== 1'b0) begin n_err++; $display("FAIL rr_idle_gap[%0d] got grant=%b busy=%b want grant=0000 busy=0", k, arb_if.grant, arb_if.busy); end
      arb_if.req[p] = 1'b1;
      tick();
    end
    arb_if.req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    arb_if.y_ready = 1'b0;
    arb_if.req     = 4'b0010;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (arb_if.grant !== 4'b0010) begin n_err++; $display("FAIL bp_grant[%0d] got=%b want=0010", k, arb_if.grant); end
      n_cmp++; if (arb_if.y_valid !== 1'b1) begin n_err++; $display("FAIL bp_y_valid[%0d] got=%b want=1", k, arb_if.y_valid); end
      n_cmp++; if (arb_if.y !== 8'h21) begin n_err++; $display("FAIL bp_y[%0d] got=%h want=21", k, arb_if.y); end
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      n_cmp++; if (dut.beat_cnt !== '0) begin n_err++; $display("FAIL bp_count[%0d] got=%0d want=0", k, dut.beat_cnt); end
`endif
      tick();
    end
    arb_if.req = 4'b0000;
    arb_if.y_ready = 1'b1;
    tick();
    n_cmp++; if (arb_if.grant !== 4'b0000) begin n_err++; $display("FAIL bp_release got=%b want=0000", arb_if.grant); end
  endtask

  task automatic test_hold();
    do_reset();
    arb_if.y_ready = 1'b1;
    arb_if.req     = 4'b0011;
    tick();
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    for (int r = 0; r < 3; r++) begin
      logic [3:0] oh;
      oh = (r == 1) ? 4'b0010 : 4'b0001;
      for (int b = 0; b < 4; b++) begin
        n_cmp++; if (arb_if.grant !== oh) begin n_err++; $display("FAIL hold_grant[%0d][%0d] got=%b want=%b", r, b, arb_if.grant, oh); end
        tick();
      end
      n_cmp++; if (arb_if.grant !== 4'b0000) begin n_err++; $display("FAIL hold_rotate_idle[%0d] got=%b want=0000", r, arb_if.grant); end
      tick();
    end
    do_reset();
    arb_if.req = 4'b0001;
    tick();
    for (int b = 0; b < 10; b++) begin
      n_cmp++; if (arb_if.grant !== 4'b0001) begin n_err++; $display("FAIL hold_alone[%0d] got=%b want=0001", b, arb_if.grant); end
      tick();
    end
`else
    for (int b = 0; b < 12; b++) begin
      n_cmp++; if (arb_if.grant !== 4'b0001) begin n_err++; $display("FAIL hold_nolimit[%0d] got=%b want=0001", b, arb_if.grant); end
      tick();
    end
    arb_if.req = 4'b0010;
    tick();
    n_cmp++; if (arb_if.grant !== 4'b0000) begin n_err++; $display("FAIL hold_release got=%b want=0000", arb_if.grant); end
    tick();
    n_cmp++; if (arb_if.grant !== 4'b0010) begin n_err++; $display("FAIL hold_next got=%b want=0010", arb_if.grant); end
`endif
    arb_if.req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    arb_if.y_ready = 1'b1;
    arb_if.req     = 4'b1000;
    tick();
    n_cmp++; if (arb_if.grant !== 4'b1000) begin n_err++; $display("FAIL ar_grant3 got=%b want=1000", arb_if.grant); end
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (arb_if.grant !== 4'b0000) begin n_err++; $display("FAIL ar_grant_clear got=%b want=0000", arb_if.grant); end
    n_cmp++; if (arb_if.y_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid_clear got=%b want=0", arb_if.y_valid); end
    n_cmp++; if (arb_if.busy !== 1'b0) begin n_err++; $display("FAIL ar_busy_clear got=%b want=0", arb_if.busy); end
    n_cmp++; if (arb_if.sel !== 2'b11) begin n_err++; $display("FAIL ar_sel_reset got=%b want=11", arb_if.sel); end
    arb_if.req = 4'b1001;
    #1;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (arb_if.grant !== 4'b0001) begin n_err++; $display("FAIL ar_restart got=%b want=0001", arb_if.grant); end
    arb_if.req = 4'b0000;
    tick();
  endtask

  initial begin
    dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'hA5; dat[3] = 8'h3C;
    arb_if.i0 = dat[0]; arb_if.i1 = dat[1]; arb_if.i2 = dat[2]; arb_if.i3 = dat[3];
    arb_if.req = 4'b0000;
    arb_if.y_ready = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
